// File: rtl/intersection_sequencer.sv
// Phase controller for a main/side road intersection with one pedestrian
// crossing. A single shared down-counter times every phase. The main road
// rests on green until there is demand, and a fault forces flashing yellow.
module intersection_sequencer #(
  parameter int CW          = 8,
  parameter int T_ALLRED    = 2,
  parameter int T_REDYEL    = 2,
  parameter int T_MIN_GREEN = 4,
  parameter int T_GREEN     = 10,
  parameter int T_BLINK     = 4,
  parameter int T_YELLOW    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       fault,
  output logic [2:0] main_ryg,
  output logic [2:0] side_ryg,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    AR_M  = 4'd0,
    M_RY  = 4'd1,
    M_G   = 4'd2,
    M_BLG = 4'd3,
    M_Y   = 4'd4,
    AR_S  = 4'd5,
    S_RY  = 4'd6,
    S_G   = 4'd7,
    S_BLG = 4'd8,
    S_Y   = 4'd9,
    FLASH = 4'd10
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   timer, timer_n;
  logic            blink, blink_n;
  logic            walk, walk_n;
  logic            ack, ack_n;
  logic            pend, pend_n;

  // Timer reload value for each state; FLASH is untimed.
  function automatic logic [CW-1:0] load_val(input state_t s);
    case (s)
      AR_M, AR_S:   load_val = CW'(T_ALLRED - 1);
      M_RY, S_RY:   load_val = CW'(T_REDYEL - 1);
      M_G:          load_val = CW'(T_MIN_GREEN - 1);
      S_G:          load_val = CW'(T_GREEN - 1);
      M_BLG, S_BLG: load_val = CW'(T_BLINK - 1);
      M_Y, S_Y:     load_val = CW'(T_YELLOW - 1);
      default:      load_val = '0;
    endcase
  endfunction

  // State, timer and flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= AR_M;
      timer <= CW'(T_ALLRED - 1);
      blink <= 1'b0;
      walk  <= 1'b0;
      ack   <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      blink <= blink_n;
      walk  <= walk_n;
      ack   <= ack_n;
      pend  <= pend_n;
    end
  end

  // Next-state, timer and flag logic.
  always_comb begin
    state_n = state;
    if (fault) begin
      state_n = FLASH;
    end else begin
      case (state)
        AR_M:    if (timer == '0) state_n = M_RY;
        M_RY:    if (timer == '0) state_n = M_G;
        M_G:     if (timer == '0 && (side_req || pend)) state_n = M_BLG;
        M_BLG:   if (timer == '0) state_n = M_Y;
        M_Y:     if (timer == '0) state_n = AR_S;
        AR_S:    if (timer == '0) state_n = S_RY;
        S_RY:    if (timer == '0) state_n = S_G;
        S_G:     if (timer == '0) state_n = S_BLG;
        S_BLG:   if (timer == '0) state_n = S_Y;
        S_Y:     if (timer == '0) state_n = AR_M;
        default: state_n = AR_M;
      endcase
    end

    // Reload on any state change; otherwise count down and hold at zero,
    // which is what lets M_G rest indefinitely.
    timer_n = timer;
    if (state_n != state) timer_n = load_val(state_n);
    else if (timer != '0) timer_n = timer - CW'(1);

    // BLG starts dark; FLASH starts lit; otherwise toggle every clock.
    blink_n = ~blink;
    if (state_n != state && (state_n == M_BLG || state_n == S_BLG)) blink_n = 1'b0;
    else if (state_n == FLASH && state != FLASH) blink_n = 1'b1;

    // Grant happens on the edge into S_G; walk is held for that green only.
    ack_n  = (state_n == S_G) && (state != S_G) && pend;
    walk_n = (state_n == S_G) && ((state == S_G) ? walk : pend);

    pend_n = pend | ped_req;
    if (fault || ack_n) pend_n = 1'b0;
  end

  // Lamp and pedestrian output decode from registered state.
  always_comb begin
    main_ryg = 3'b100;
    side_ryg = 3'b100;
    case (state)
      M_RY:  main_ryg = 3'b110;
      M_G:   main_ryg = 3'b001;
      M_BLG: main_ryg = {2'b00, blink};
      M_Y:   main_ryg = 3'b010;
      S_RY:  side_ryg = 3'b110;
      S_G:   side_ryg = 3'b001;
      S_BLG: side_ryg = {2'b00, blink};
      S_Y:   side_ryg = 3'b010;
      FLASH: begin
        main_ryg = {1'b0, blink, 1'b0};
        side_ryg = {1'b0, blink, 1'b0};
      end
      default: ;
    endcase
  end

  assign ped_walk = walk;
  assign ped_ack  = ack;
  assign phase    = state;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Table-driven bench for intersection_sequencer: one record per clock with
// inputs and the outputs expected during that clock, plus a hand-written
// asynchronous reset check.
module tb_intersection_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       fault = 1'b0;
  logic [2:0] main_ryg, side_ryg;
  logic       ped_walk, ped_ack;
  logic [3:0] phase;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  intersection_sequencer #(
    .CW(8), .T_ALLRED(2), .T_REDYEL(2), .T_MIN_GREEN(4),
    .T_GREEN(10), .T_BLINK(4), .T_YELLOW(3)
  ) dut (
    .clock(clock), .reset(reset), .side_req(side_req), .ped_req(ped_req),
    .fault(fault), .main_ryg(main_ryg), .side_ryg(side_ryg),
    .ped_walk(ped_walk), .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clock = ~clock;

  localparam logic [2:0] R = 3'b100, RY = 3'b110, G = 3'b001, Y = 3'b010, O = 3'b000;
  localparam logic [3:0] P_ARM = 4'd0, P_MRY = 4'd1, P_MG = 4'd2, P_MBLG = 4'd3,
                         P_MY = 4'd4, P_ARS = 4'd5, P_SRY = 4'd6, P_SG = 4'd7,
                         P_SBLG = 4'd8, P_SY = 4'd9, P_FL = 4'd10;

  typedef struct {
    logic       r, sr, pr, f;
    logic [2:0] m, s;
    logic       w, a;
    logic [3:0] ph;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int unsigned n, input logic r, sr, pr, f,
                     input logic [2:0] m, s, input logic w, a, input logic [3:0] ph);
    vec_t v;
    v.r = r; v.sr = sr; v.pr = pr; v.f = f;
    v.m = m; v.s = s; v.w = w; v.a = a; v.ph = ph;
    for (int unsigned i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic start();
    add(2, 0, 0, 0, 0, R,  R, 0, 0, P_ARM);
    add(2, 0, 0, 0, 0, RY, R, 0, 0, P_MRY);
  endtask

  task automatic main_clear();
    add(1, 0, 0, 0, 0, O, R,  0, 0, P_MBLG);
    add(1, 0, 0, 0, 0, G, R,  0, 0, P_MBLG);
    add(1, 0, 0, 0, 0, O, R,  0, 0, P_MBLG);
    add(1, 0, 0, 0, 0, G, R,  0, 0, P_MBLG);
    add(3, 0, 0, 0, 0, Y, R,  0, 0, P_MY);
    add(2, 0, 0, 0, 0, R, R,  0, 0, P_ARS);
    add(2, 0, 0, 0, 0, R, RY, 0, 0, P_SRY);
  endtask

  task automatic side_green(input logic acked, input logic ped_on_ack);
    add(1, 0, 0, ped_on_ack, 0, R, G, acked, acked, P_SG);
    add(9, 0, 0, 0,          0, R, G, acked, 1'b0,  P_SG);
  endtask

  task automatic side_blink();
    add(1, 0, 0, 0, 0, R, O, 0, 0, P_SBLG);
    add(1, 0, 0, 0, 0, R, G, 0, 0, P_SBLG);
    add(1, 0, 0, 0, 0, R, O, 0, 0, P_SBLG);
    add(1, 0, 0, 0, 0, R, G, 0, 0, P_SBLG);
  endtask

  task automatic side_tail();
    side_blink();
    add(3, 0, 0, 0, 0, R, Y, 0, 0, P_SY);
    start();
  endtask

  // Main and side must never both be non-red outside flashing mode.
  always begin
    @(negedge clock);
    #2;
    if (!reset && phase != P_FL && main_ryg != R && side_ryg != R) begin
      nerr++;
      $display("FAIL conflict: main=%b side=%b phase=%0d", main_ryg, side_ryg, phase);
    end
  end

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got {main,side,walk,ack,phase}=%b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
               name, got[11:9], got[8:6], got[5], got[4], got[3:0],
               exp[11:9], exp[8:6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  initial begin
    bit found;

    // Test 1: reset, then rest on main green with no demand.
    add(2, 1, 0, 0, 0, R, R, 0, 0, P_ARM);
    start();
    add(120, 0, 0, 0, 0, G, R, 0, 0, P_MG);

    // Test 2: side demand from the second main-green cycle, full cycle.
    add(1, 1, 0, 0, 0, R, R, 0, 0, P_ARM);
    start();
    add(1, 0, 0, 0, 0, G, R, 0, 0, P_MG);
    add(3, 0, 1, 0, 0, G, R, 0, 0, P_MG);
    main_clear();
    side_green(0, 0);
    side_tail();
    add(3, 0, 0, 0, 0, G, R, 0, 0, P_MG);

    // Test 3: pedestrian press during resting green, served once.
    add(1, 0, 0, 1, 0, G, R, 0, 0, P_MG);
    add(1, 0, 0, 0, 0, G, R, 0, 0, P_MG);
    main_clear();
    side_green(1, 0);
    side_tail();
    add(6, 0, 0, 0, 0, G, R, 0, 0, P_MG);

    // Test 4: press on the ack cycle is served in the following side phase.
    add(1, 0, 0, 1, 0, G, R, 0, 0, P_MG);
    add(1, 0, 0, 0, 0, G, R, 0, 0, P_MG);
    main_clear();
    side_green(1, 1);
    side_tail();
    add(4, 0, 0, 0, 0, G, R, 0, 0, P_MG);
    main_clear();
    side_green(1, 0);
    side_tail();
    add(3, 0, 0, 0, 0, G, R, 0, 0, P_MG);

    // Test 5: fault mid side green, pending press discarded.
    add(1, 0, 1, 0, 0, G, R, 0, 0, P_MG);
    main_clear();
    add(1, 0, 0, 0, 0, R, G, 0, 0, P_SG);
    add(1, 0, 0, 1, 0, R, G, 0, 0, P_SG);
    add(2, 0, 0, 0, 0, R, G, 0, 0, P_SG);
    add(1, 0, 0, 0, 1, R, G, 0, 0, P_SG);
    add(1, 0, 0, 0, 1, Y, Y, 0, 0, P_FL);
    add(1, 0, 0, 1, 1, O, O, 0, 0, P_FL);
    add(1, 0, 0, 0, 1, Y, Y, 0, 0, P_FL);
    add(1, 0, 0, 0, 0, O, O, 0, 0, P_FL);
    start();
    add(6, 0, 0, 0, 0, G, R, 0, 0, P_MG);

    // Test 6: reset during side yellow.
    add(1, 0, 1, 0, 0, G, R, 0, 0, P_MG);
    main_clear();
    side_green(0, 0);
    side_blink();
    add(1, 0, 0, 0, 0, R, Y, 0, 0, P_SY);
    add(1, 1, 0, 0, 0, R, R, 0, 0, P_ARM);
    start();
    add(5, 0, 0, 0, 0, G, R, 0, 0, P_MG);

    foreach (tbl[i]) begin
      @(negedge clock);
      reset = tbl[i].r; side_req = tbl[i].sr; ped_req = tbl[i].pr; fault = tbl[i].f;
      #1;
      check($sformatf("vec%0d", i), {main_ryg, side_ryg, ped_walk, ped_ack, phase},
            {tbl[i].m, tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].ph});
    end

    // Reset asserted between clock edges during side green takes effect at once.
    side_req = 1'b1;
    found = 1'b0;
    for (int unsigned c = 0; c < 60 && !found; c++) begin
      @(negedge clock);
      #1;
      if (phase == P_SG) found = 1'b1;
    end
    side_req = 1'b0;
    nvec++;
    if (!found) begin
      nerr++;
      $display("FAIL reach_sg: phase=%0d never reached required %0d", phase, P_SG);
    end
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check("async_reset", {main_ryg, side_ryg, ped_walk, ped_ack, phase}, {R, R, 2'b00, P_ARM});
    @(negedge clock);
    reset = 1'b0;
    #1 check("post_reset_arm", {main_ryg, side_ryg, ped_walk, ped_ack, phase}, {R, R, 2'b00, P_ARM});
    @(negedge clock);
    @(negedge clock);
    #1 check("post_reset_mry", {main_ryg, side_ryg, ped_walk, ped_ack, phase}, {RY, R, 2'b00, P_MRY});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
